// File: rtl/n_bit_synchronous_updown_counter.sv
`timescale 1ns/1ps
// n_bit_synchronous_updown_counter
//
// Parameterised N-bit synchronous binary up/down counter built in the
// classic T-flip-flop style: every bit is clocked by clk, and bit i toggles
// when all lower-order bits are 1 (counting up) or all are 0 (counting down).
// The counter runs continuously while reset is low and wraps modulo 2^N in
// both directions. There is no terminal-count output and no saturation.
//
// Parameters:
//   N      counter width in bits, legal range 1..32 (default 4)
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  asynchronous, active-high; forces count to 0 while high
//   m      mode: 0 = count up, 1 = count down; sampled at each rising edge,
//          must be stable around the edge (not synchronised here)
//   count  current counter value, driven directly from the registers
module n_bit_synchronous_updown_counter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         m,
  output logic [N-1:0] count
);

  // Per-bit toggle enables.
  logic [N-1:0] t;

  // Up:   t[i] = &count[i-1:0]
  // Down: t[i] = &~count[i-1:0]
  // Built as a running AND chain so each enable reuses the one below it.
  // Selecting the mode per bit (rather than choosing between two full chains)
  // keeps the chain a single structure and gives identical results.
  always_comb begin
    t    = '0;
    t[0] = 1'b1;
    for (int unsigned i = 1; i < N; i++) begin
      t[i] = t[i-1] & (m ? ~count[i-1] : count[i-1]);
    end
  end

  // All bits toggle together on the same edge; no ripple clocking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count ^ t;
    end
  end

endmodule

// File: tb/tb_n_bit_synchronous_updown_counter.sv
`timescale 1ns/1ps
module tb_n_bit_synchronous_updown_counter;

  logic       clk;
  logic       reset;
  logic       m;
  logic [3:0] count;

  // Separate stimulus for the width sweep instances.
  logic       rs;
  logic       ms;
  logic [0:0] count1;
  logic [2:0] count3;
  logic [7:0] count8;

  int tests = 0;
  int fails = 0;

  n_bit_synchronous_updown_counter #(.N(4)) dut (
    .clk(clk), .reset(reset), .m(m), .count(count)
  );
  n_bit_synchronous_updown_counter #(.N(1)) dut1 (
    .clk(clk), .reset(rs), .m(ms), .count(count1)
  );
  n_bit_synchronous_updown_counter #(.N(3)) dut3 (
    .clk(clk), .reset(rs), .m(ms), .count(count3)
  );
  n_bit_synchronous_updown_counter #(.N(8)) dut8 (
    .clk(clk), .reset(rs), .m(ms), .count(count8)
  );

  // Rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic mm, input int e);
    vec_t v;
    v.m   = mm;
    v.exp = 4'(e);
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%h), expected %0d", name, act, act, exp);
    end
  endtask

  // Drive m at the falling edge, sample #1 after the next rising edge.
  task automatic step_check(input string name, input logic mm, input logic [3:0] exp);
    @(negedge clk);
    m = mm;
    @(posedge clk);
    #1;
    check(name, 32'(count), 32'(exp));
  endtask

  // Pulse reset for 3 ns between edges; count must clear without an edge.
  task automatic reset_pulse(input string name, input logic m_next, input logic [3:0] exp_next);
    @(posedge clk);
    #3;
    reset = 1'b1;
    m     = m_next;
    #1;
    check({name, "_async_clear"}, 32'(count), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check({name, "_held_after_release"}, 32'(count), 32'd0);
    @(posedge clk);
    #1;
    check({name, "_first_edge"}, 32'(count), 32'(exp_next));
  endtask

  initial begin
    int down_seq[10] = '{7, 6, 5, 4, 3, 2, 1, 0, 15, 14};
    int up_seq[7]    = '{15, 0, 1, 2, 3, 4, 5};
    int tail_seq[4]  = '{6, 7, 8, 9};
    logic [0:0] ref1;
    logic [2:0] ref3;
    logic [7:0] ref8;

    // 40 up edges from 0: 1..15, 0, 1..15, 0, 1..8
    for (int k = 1; k <= 40; k++) add(1'b0, k % 16);
    // Down from 8, through the 0 -> 15 wrap
    foreach (down_seq[k]) add(1'b1, down_seq[k]);
    // Up from 14 to 5, then reverse for one edge and back
    foreach (up_seq[k]) add(1'b0, up_seq[k]);
    add(1'b1, 4);
    add(1'b0, 5);
    foreach (tail_seq[k]) add(1'b0, tail_seq[k]);

    // Reset hold: reset high for 17 ns covers the edges at 5 and 15.
    reset = 1'b1;
    m     = 1'b0;
    rs    = 1'b1;
    ms    = 1'b0;
    #3;
    check("reset_t3", 32'(count), 32'd0);
    #7;
    check("reset_t10", 32'(count), 32'd0);
    #6;
    check("reset_t16", 32'(count), 32'd0);
    #1;
    reset = 1'b0;
    // First edge after release is t=25 and must give 1.
    foreach (vecs[i]) begin
      step_check($sformatf("vec%0d", i), vecs[i].m, vecs[i].exp);
    end

    // count is 9 here; async clear, then resume up and down.
    check("pre_reset_value", 32'(count), 32'd9);
    reset_pulse("rst_up", 1'b0, 4'd1);
    reset_pulse("rst_down", 1'b1, 4'd15);
    step_check("after_rst_down", 1'b1, 4'd14);

    // Width sweep: N=1, 3, 8 against a modulo reference, up then down.
    @(negedge clk);
    check("sweep_reset_n1", 32'(count1), 32'd0);
    check("sweep_reset_n3", 32'(count3), 32'd0);
    check("sweep_reset_n8", 32'(count8), 32'd0);
    rs   = 1'b0;
    ms   = 1'b0;
    ref1 = '0;
    ref3 = '0;
    ref8 = '0;
    for (int k = 0; k < 258; k++) begin
      @(posedge clk);
      #1;
      ref1 = ref1 + 1'b1;
      ref3 = ref3 + 3'd1;
      ref8 = ref8 + 8'd1;
      check($sformatf("up_n1_%0d", k), 32'(count1), 32'(ref1));
      check($sformatf("up_n3_%0d", k), 32'(count3), 32'(ref3));
      check($sformatf("up_n8_%0d", k), 32'(count8), 32'(ref8));
    end
    @(negedge clk);
    ms = 1'b1;
    for (int k = 0; k < 258; k++) begin
      @(posedge clk);
      #1;
      ref1 = ref1 - 1'b1;
      ref3 = ref3 - 3'd1;
      ref8 = ref8 - 8'd1;
      check($sformatf("dn_n1_%0d", k), 32'(count1), 32'(ref1));
      check($sformatf("dn_n3_%0d", k), 32'(count3), 32'(ref3));
      check($sformatf("dn_n8_%0d", k), 32'(count8), 32'(ref8));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
